// File: rtl/video_timing_generator.sv
// video_timing_generator
//   Raster timing generator driven by a single pixel clock. Produces hsync,
//   vsync and data-enable, the active-area pixel coordinates and frame/line
//   start strobes. Timing parameters are captured into shadow registers on
//   enable and at frame boundaries (when an update is pending). A stop
//   request lets the current frame finish before the generator goes idle.
//
// Ports
//   clk, reset          pixel clock, synchronous active-high reset
//   ctl_enable          level: 1 = run, 0 = stop at end of current frame
//   ctl_busy            1 while a frame is being generated
//   param_update        pulse: load shadow parameters at the next frame boundary
//   param_pending       1 from the update pulse until the load happens
//   param_h*/param_v*   horizontal timing (pixels) / vertical timing (lines)
//   param_*sync_pol     sync polarity, 1 = active-high
//   out_hsync/vsync/de  registered timing outputs
//   out_x, out_y        active-area coordinates, 0 outside DE
//   out_frame_start     strobe for the output of h=0, v=0
//   out_line_start      strobe for the output of h=0
//
// Build option
//   VIDEO_TIMING_GEN_COORD_EN  when defined, out_x/out_y carry coordinates;
//                              otherwise they are tied to 0.

module video_timing_generator #(
    parameter int unsigned H_COUNTER_WIDTH = 12,
    parameter int unsigned V_COUNTER_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ctl_enable,
    output logic                       ctl_busy,
    input  logic                       param_update,
    output logic                       param_pending,
    input  logic [H_COUNTER_WIDTH-1:0] param_htotal,
    input  logic [H_COUNTER_WIDTH-1:0] param_hdisp_start,
    input  logic [H_COUNTER_WIDTH-1:0] param_hdisp_end,
    input  logic [H_COUNTER_WIDTH-1:0] param_hsync_start,
    input  logic [H_COUNTER_WIDTH-1:0] param_hsync_end,
    input  logic [V_COUNTER_WIDTH-1:0] param_vtotal,
    input  logic [V_COUNTER_WIDTH-1:0] param_vdisp_start,
    input  logic [V_COUNTER_WIDTH-1:0] param_vdisp_end,
    input  logic [V_COUNTER_WIDTH-1:0] param_vsync_start,
    input  logic [V_COUNTER_WIDTH-1:0] param_vsync_end,
    input  logic                       param_hsync_pol,
    input  logic                       param_vsync_pol,
    output logic                       out_hsync,
    output logic                       out_vsync,
    output logic                       out_de,
    output logic [H_COUNTER_WIDTH-1:0] out_x,
    output logic [V_COUNTER_WIDTH-1:0] out_y,
    output logic                       out_frame_start,
    output logic                       out_line_start
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    typedef struct packed {
        logic [H_COUNTER_WIDTH-1:0] htotal;
        logic [H_COUNTER_WIDTH-1:0] hdisp_start;
        logic [H_COUNTER_WIDTH-1:0] hdisp_end;
        logic [H_COUNTER_WIDTH-1:0] hsync_start;
        logic [H_COUNTER_WIDTH-1:0] hsync_end;
        logic [V_COUNTER_WIDTH-1:0] vtotal;
        logic [V_COUNTER_WIDTH-1:0] vdisp_start;
        logic [V_COUNTER_WIDTH-1:0] vdisp_end;
        logic [V_COUNTER_WIDTH-1:0] vsync_start;
        logic [V_COUNTER_WIDTH-1:0] vsync_end;
        logic                       hpol;
        logic                       vpol;
    } timing_t;

    localparam logic [H_COUNTER_WIDTH-1:0] H_ONE = {{(H_COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [V_COUNTER_WIDTH-1:0] V_ONE = {{(V_COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_e                     state_q, state_d;
    logic [H_COUNTER_WIDTH-1:0] h_q, h_d;
    logic [V_COUNTER_WIDTH-1:0] v_q, v_d;
    logic                       pending_q, pending_d;
    timing_t                    sh_q, sh_d;

    logic hsync_q, vsync_q, de_q, fs_q, ls_q;
    logic hsync_d, vsync_d, de_d, fs_d, ls_d;

    logic busy;
    logic h_last, v_last, frame_last;
    logic hact, vact, hs_raw, vs_raw;
    logic load;

    assign busy = (state_q != ST_IDLE);

    // A total of 0 or 1 pins the counter at 0; the explicit test also keeps
    // total-1 from underflowing.
    assign h_last     = (sh_q.htotal <= H_ONE) || (h_q >= sh_q.htotal - H_ONE);
    assign v_last     = (sh_q.vtotal <= V_ONE) || (v_q >= sh_q.vtotal - V_ONE);
    assign frame_last = h_last && v_last;

    assign hact   = (h_q >= sh_q.hdisp_start) && (h_q < sh_q.hdisp_end);
    assign vact   = (v_q >= sh_q.vdisp_start) && (v_q < sh_q.vdisp_end);
    assign hs_raw = (h_q >= sh_q.hsync_start) && (h_q < sh_q.hsync_end);
    assign vs_raw = (v_q >= sh_q.vsync_start) && (v_q < sh_q.vsync_end);

    // Next state, counters, shadow load and pending flag.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        sh_d      = sh_q;
        pending_d = pending_q | param_update;
        load      = 1'b0;

        if (busy) begin
            if (frame_last) begin
                h_d = '0;
                v_d = '0;
            end else if (h_last) begin
                h_d = '0;
                v_d = v_q + V_ONE;
            end else begin
                h_d = h_q + H_ONE;
            end
        end

        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (ctl_enable) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!ctl_enable) begin
                    state_d = ST_STOPPING;
                end
                // pending_d already includes an update arriving this cycle
                if (frame_last && pending_d) begin
                    load = 1'b1;
                end
            end
            ST_STOPPING: begin
                if (ctl_enable) begin
                    state_d = ST_RUN;
                end else if (frame_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            sh_d = '{htotal:      param_htotal,
                     hdisp_start: param_hdisp_start,
                     hdisp_end:   param_hdisp_end,
                     hsync_start: param_hsync_start,
                     hsync_end:   param_hsync_end,
                     vtotal:      param_vtotal,
                     vdisp_start: param_vdisp_start,
                     vdisp_end:   param_vdisp_end,
                     vsync_start: param_vsync_start,
                     vsync_end:   param_vsync_end,
                     hpol:        param_hsync_pol,
                     vpol:        param_vsync_pol};
            pending_d = 1'b0;
        end
    end

    // Output stage: one register after the counter state. When idle the
    // syncs rest at the inactive level of the shadow polarity.
    always_comb begin
        hsync_d = ~sh_q.hpol;
        vsync_d = ~sh_q.vpol;
        de_d    = 1'b0;
        fs_d    = 1'b0;
        ls_d    = 1'b0;
        if (busy) begin
            hsync_d = ~(hs_raw ^ sh_q.hpol);
            vsync_d = ~(vs_raw ^ sh_q.vpol);
            de_d    = hact && vact;
            fs_d    = (h_q == '0) && (v_q == '0);
            ls_d    = (h_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            pending_q <= 1'b0;
            sh_q      <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pending_q <= pending_d;
            sh_q      <= sh_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
        end
    end

`ifdef VIDEO_TIMING_GEN_COORD_EN
    logic [H_COUNTER_WIDTH-1:0] x_q, x_d;
    logic [V_COUNTER_WIDTH-1:0] y_q, y_d;

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (de_d) begin
            x_d = h_q - sh_q.hdisp_start;
            y_d = v_q - sh_q.vdisp_start;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign out_x = x_q;
    assign out_y = y_q;
`else
    assign out_x = '0;
    assign out_y = '0;
`endif

    assign ctl_busy        = busy;
    assign param_pending   = pending_q;
    assign out_hsync       = hsync_q;
    assign out_vsync       = vsync_q;
    assign out_de          = de_q;
    assign out_frame_start = fs_q;
    assign out_line_start  = ls_q;

endmodule

// File: doc/video_timing_generator.md
# video_timing_generator

Parametrised successor to the existing vsync generator core. Produces hsync/vsync/DE plus active-area pixel coordinates and frame/line-start strobes from a single pixel clock. Timing parameters are double-buffered and applied only at frame boundaries, and stop requests take effect gracefully at end of frame. The block sits between the register front-end and the DVI/TMDS encoder.

## Interface
- H_COUNTER_WIDTH, 12, width of horizontal counter and all H parameters
- V_COUNTER_WIDTH, 12, width of vertical counter and all V parameters
- clk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- ctl_enable  in  1  level; 1 = run, 0 = stop at end of current frame
- ctl_busy  out  1  1 while the generator is running a frame
- param_update  in  1  single-cycle pulse; requests a shadow-parameter load at the next frame boundary
- param_pending  out  1  1 from the pulse until the load occurs
- param_htotal, param_hdisp_start, param_hdisp_end, param_hsync_start, param_hsync_end  in  H_COUNTER_WIDTH  H timing, in pixel clocks
- param_vtotal, param_vdisp_start, param_vdisp_end, param_vsync_start, param_vsync_end  in  V_COUNTER_WIDTH  V timing, in lines
- param_hsync_pol, param_vsync_pol  in  1  0 = negative, 1 = positive
- out_hsync, out_vsync, out_de  out  1  registered timing outputs
- out_x  out  H_COUNTER_WIDTH  active-area column; 0 outside DE
- out_y  out  V_COUNTER_WIDTH  active-area row; 0 outside DE
- out_frame_start  out  1  1-cycle strobe aligned with the output for h=0, v=0
- out_line_start  out  1  1-cycle strobe aligned with the output for h=0, every line

## Operation
- The FSM has three states:
  - IDLE → RUN on ctl_enable=1. This transition loads every shadow register from param_* and clears h and v to 0.
  - RUN → STOPPING on ctl_enable=0.
  - STOPPING → RUN on ctl_enable=1. The stop is cancelled, the frame is not restarted, and no parameter reload occurs.
  - STOPPING → IDLE at the last cycle of the frame (h=htotal-1, v=vtotal-1).
- ctl_busy=1 in RUN and STOPPING.
- h counts 0..htotal-1. At wrap, v increments, counting 0..vtotal-1.
  - Wrap compares use >= (h>=htotal-1, v>=vtotal-1).
  - A shadow htotal/vtotal of 0 or 1 behaves as 1: h is held at 0.
- Comparisons use half-open ranges, [start, end), on the shadow values:
  - hactive = h in [hdisp_start, hdisp_end)
  - vactive = v in [vdisp_start, vdisp_end)
  - hsync_raw = h in [hsync_start, hsync_end)
  - vsync_raw = v in [vsync_start, vsync_end)
- Output equations:
  - out_de = hactive & vactive
  - out_hsync = hsync_raw XNOR pol. The line is at the active level when raw=1. The inactive level is !pol.
  - out_x = h - hdisp_start, out_y = v - vdisp_start. Computed modulo counter width; forced to 0 when not DE.
- Parameter update:
  - A param_update pulse sets param_pending.
  - At the last cycle of a frame in RUN with pending=1, the shadow registers load from the live param_* inputs and pending clears.
  - If param_update arrives on that same last cycle, it is applied at that same boundary.
  - A pulse while IDLE leaves pending set. The next enable loads the parameters anyway and clears pending.
- In IDLE:
  - h=v=0 and are frozen.
  - out_de=0, out_x=out_y=0, strobes=0.
  - Syncs are driven to the inactive level of the shadow polarity.

## Timing
- Reset values:
  - FSM=IDLE, ctl_busy=0, param_pending=0.
  - Shadow registers all 0, so pol=0 and out_hsync=out_vsync=1.
  - out_de=0, out_x=out_y=0, out_frame_start=out_line_start=0.
- Reset has priority over all inputs, including mid-frame. Outputs return to reset values on the next edge.
- Enable latency: ctl_enable=1 sampled at edge N gives ctl_busy=1 and counter (0,0) after edge N. out_frame_start=1 after edge N+1.
- Output latency: all out_* are exactly one register stage after the counter state.
- Stop: ctl_busy falls on the edge after the last frame cycle. Output for that last cycle appears in the same edge. Outputs are idle values from the following cycle onward.
- Parameter load: the new shadow values govern the first cycle of the next frame (h=0, v=0). Mid-frame changes on param_* have no effect.

## Configuration
- VIDEO_TIMING_GEN_COORD_EN
  - Defined: out_x/out_y are computed as specified.
  - Undefined: out_x/out_y are tied to 0, and their subtractors and registers are omitted. All other behaviour is identical.

## Test plan
- Reset, then hold ctl_enable=0 for 10 cycles.
  - All outputs stay at reset values: hsync=vsync=1, de=0, busy=0.
- VGA timing: htotal=800, hdisp 112..752, hsync 0..96, vtotal=525, vdisp 12..492, vsync 0..2, pol=0, enable held.
  - Frame period is 420000 clocks.
  - 307200 DE cycles per frame.
  - hsync low for 96 clocks per line.
  - out_x spans 0..639 and out_y spans 0..479.
  - out_frame_start occurs exactly once per frame.
- Change htotal to 900 and pulse param_update mid-frame.
  - The current frame remains 800-clock lines.
  - The next frame uses 900.
  - param_pending falls at the boundary.
- Deassert ctl_enable at line 100.
  - The frame completes to v=524.
  - busy falls one edge after the last cycle.
  - Syncs go inactive.
- Deassert ctl_enable, then reassert before frame end.
  - busy never drops.
  - The frame continues without a restart.
- pol=1 and assert reset mid-frame.
  - Before reset, syncs are active-high.
  - After reset, all outputs return to reset values on the next edge.
